// File: rtl/div_arbiter_pkg.sv
// Shared types and constants for the divider arbiter and its round-robin picker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_arbiter_pkg;

  localparam int OPW         = 10;  // divider operand / quotient width
  localparam int ID_W        = 3;   // requester index width (up to 8 requesters)
  localparam int CNT_W       = 8;   // WAIT-state cycle counter width (TIMEOUT <= 255)
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_RESP
  } state_t;

  // Registered response held while the consumer is not ready.
  typedef struct packed {
    logic [OPW-1:0] q;
    logic           dvz;
    logic           ovf;
    logic           err;
  } rsp_t;

endpackage

// File: rtl/div_arbiter_rr_pick.sv
// Round-robin pick: first set req bit scanning upward from last_id+1, wrapping at N_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is taken.
module rr_pick
  import div_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_id,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  id,
  output logic             any
);

  // Walk the candidates in priority order; the first live one wins.
  always_comb begin
    grant = '0;
    id    = '0;
    any   = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!any && req[j] && (j == (int'(last_id) + k) % N_REQ)) begin
          any      = 1'b1;
          grant[j] = 1'b1;
          id       = ID_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one divider among N_REQ requesters, one division in flight, round-robin order.
// Latency: gnt same cycle as pick, div_start next cycle, rsp one cycle after div_valid/timeout.
// Backpressure: rsp held until rsp_ready; no new grant is issued while a result is pending.
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*OPW-1:0] req_a,
  input  logic [N_REQ*OPW-1:0] req_b,
  output logic [N_REQ-1:0]     gnt,
  output logic                 div_start,
  output logic                 div_sclr,
  output logic [OPW-1:0]       div_a,
  output logic [OPW-1:0]       div_b,
  input  logic [OPW-1:0]       div_q,
  input  logic                 div_dvz,
  input  logic                 div_ovf,
  input  logic                 div_busy,
  input  logic                 div_valid,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [OPW-1:0]       rsp_q,
  output logic                 rsp_dvz,
  output logic                 rsp_ovf,
  output logic                 rsp_err
);

  state_t           state, state_nxt;
  logic [ID_W-1:0]  last_id, cap_id, pick_id;
  logic [N_REQ-1:0] pick_grant;
  logic             pick_any;
  logic [OPW-1:0]   op_a, op_b, sel_a, sel_b;
  logic [CNT_W-1:0] wait_cnt;
  logic             rst_done;  // low until the first edge after reset release
  logic             take;
  logic             timeout_hit;
  rsp_t             rsp;

  // Sequencing relies on div_valid alone; busy is informational only.
  logic unused_busy;
  assign unused_busy = div_busy;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (req),
    .last_id(last_id),
    .grant  (pick_grant),
    .id     (pick_id),
    .any    (pick_any)
  );

  // Grants are held off for the divider-clear cycle that follows reset.
  assign take        = (state == ST_IDLE) && rst_done && pick_any;
  // div_valid in the final counted cycle takes priority over the timeout.
  assign timeout_hit = (state == ST_WAIT) && !div_valid && (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Select the winning requester's operands.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (pick_grant[j]) begin
        sel_a = req_a[j*OPW +: OPW];
        sel_b = req_b[j*OPW +: OPW];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (take) state_nxt = ST_LAUNCH;
      ST_LAUNCH: state_nxt = ST_WAIT;
      ST_WAIT:   if (div_valid || timeout_hit) state_nxt = ST_RESP;
      ST_RESP:   if (rsp_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs; operands are only driven while the divider owns them.
  always_comb begin
    gnt       = take ? pick_grant : '0;
    div_start = (state == ST_LAUNCH);
    div_a     = (state == ST_LAUNCH || state == ST_WAIT) ? op_a : '0;
    div_b     = (state == ST_LAUNCH || state == ST_WAIT) ? op_b : '0;
    rsp_valid = (state == ST_RESP);
  end

  // Operand capture, wait counter, response register, divider clear and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_id  <= ID_W'(N_REQ - 1);
      cap_id   <= '0;
      op_a     <= '0;
      op_b     <= '0;
      wait_cnt <= '0;
      rst_done <= 1'b0;
      div_sclr <= 1'b0;
      rsp      <= '0;
    end else begin
      rst_done <= 1'b1;
      // A division may have been abandoned by reset, so clear the divider once on the way out.
      div_sclr <= !rst_done || timeout_hit;
      if (take) begin
        op_a   <= sel_a;
        op_b   <= sel_b;
        cap_id <= pick_id;
      end
      if (state == ST_LAUNCH)
        wait_cnt <= '0;
      else if (state == ST_WAIT && !div_valid && !timeout_hit)
        wait_cnt <= wait_cnt + CNT_W'(1);
      if (state == ST_WAIT && div_valid)
        rsp <= '{q: div_q, dvz: div_dvz, ovf: div_ovf, err: 1'b0};
      else if (timeout_hit)
        rsp <= '{q: '0, dvz: 1'b0, ovf: 1'b0, err: 1'b1};
      if (state == ST_RESP && rsp_ready)
        last_id <= cap_id;
    end
  end

  assign rsp_id  = cap_id;
  assign rsp_q   = rsp.q;
  assign rsp_dvz = rsp.dvz;
  assign rsp_ovf = rsp.ovf;
  assign rsp_err = rsp.err;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural divider; a second instance never gets div_valid.
// Latency: n/a.
// Backpressure: rsp_ready driven per scenario.
module tb_div_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*10-1:0] req_a, req_b;
  logic           rsp_ready;

  logic [N-1:0] gnt;
  logic         div_start, div_sclr, rsp_valid, rsp_dvz, rsp_ovf, rsp_err;
  logic [9:0]   div_a, div_b, rsp_q;
  logic [2:0]   rsp_id;

  logic [9:0] div_q     = '0;
  logic       div_dvz   = 1'b0;
  logic       div_valid = 1'b0;
  logic       div_ovf;
  logic       div_busy;

  logic [N-1:0] t_gnt;
  logic         t_div_start, t_div_sclr, t_rsp_valid, t_rsp_dvz, t_rsp_ovf, t_rsp_err;
  logic [9:0]   t_div_a, t_div_b, t_rsp_q;
  logic [2:0]   t_rsp_id;

  // Fixed operands: id0 100/7, id1 300/9, id2 55/0, id3 1000/3.
  assign req_a = {10'd1000, 10'd55, 10'd300, 10'd100};
  assign req_b = {10'd3, 10'd0, 10'd9, 10'd7};

  // Hand-computed quotients (divide by zero returns all ones from the model).
  int exp_q [4] = '{14, 33, 1023, 333};

  div_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b), .gnt(gnt),
    .div_start(div_start), .div_sclr(div_sclr), .div_a(div_a), .div_b(div_b),
    .div_q(div_q), .div_dvz(div_dvz), .div_ovf(div_ovf), .div_busy(div_busy),
    .div_valid(div_valid), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_q(rsp_q), .rsp_dvz(rsp_dvz), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err)
  );

  div_arbiter #(.N_REQ(N), .TIMEOUT(8)) dut_to (
    .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b), .gnt(t_gnt),
    .div_start(t_div_start), .div_sclr(t_div_sclr), .div_a(t_div_a), .div_b(t_div_b),
    .div_q(10'd0), .div_dvz(1'b0), .div_ovf(1'b0), .div_busy(1'b0),
    .div_valid(1'b0), .rsp_valid(t_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(t_rsp_id),
    .rsp_q(t_rsp_q), .rsp_dvz(t_rsp_dvz), .rsp_ovf(t_rsp_ovf), .rsp_err(t_rsp_err)
  );

  // Behavioural divider: m_lat cycles after div_start it pulses div_valid; div_sclr aborts.
  int         m_lat  = 12;
  int         m_cnt  = 0;
  logic       m_busy = 1'b0;
  logic [9:0] m_a = '0, m_b = '0;
  assign div_ovf  = 1'b0;
  assign div_busy = m_busy;

  always @(posedge clk) begin
    if (div_sclr) begin
      m_busy    <= 1'b0;
      div_valid <= 1'b0;
    end else if (div_start) begin
      m_busy    <= 1'b1;
      m_cnt     <= m_lat;
      m_a       <= div_a;
      m_b       <= div_b;
      div_valid <= 1'b0;
    end else if (m_busy && m_cnt == 1) begin
      m_busy    <= 1'b0;
      div_valid <= 1'b1;
      div_q     <= (m_b == 0) ? 10'h3FF : m_a / m_b;
      div_dvz   <= (m_b == 0);
    end else begin
      div_valid <= 1'b0;
      if (m_busy && m_cnt > 1) m_cnt <= m_cnt - 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(input string tag, input int limit);
    int n = 0;
    while (!rsp_valid && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rsp_seen"}, rsp_valid, 1);
  endtask

  function automatic int oh2id(input logic [N-1:0] g);
    int r = -1;
    for (int i = 0; i < N; i++) if (g[i]) r = i;
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_ids [5] = '{0, 1, 2, 3, 0};
    int bad, n, id;
    logic [9:0] s_q;
    logic [2:0] s_id;
    logic       s_dvz;

    // Reset: outputs quiet even with every request raised.
    rst_n = 1'b0; req = 4'b1111; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_start", div_start, 0);
    chk("rst_sclr", div_sclr, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_div_a", div_a, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_t_gnt", t_gnt, 0);
    req = '0; rst_n = 1'b1;
    @(negedge clk);
    chk("sclr_after_rst", div_sclr, 1);
    @(negedge clk);
    chk("sclr_one_cycle", div_sclr, 0);

    // Single request 100/7 from id0.
    req = 4'b0001; #1;
    chk("single_gnt", gnt, 4'b0001);
    @(negedge clk); req = '0;
    chk("single_gnt_pulse", gnt, 0);
    chk("single_start", div_start, 1);
    chk("single_div_a", div_a, 100);
    chk("single_div_b", div_b, 7);
    bad = 0; n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk); n++;
      if (div_start || gnt != 0) bad++;
      if (!rsp_valid && div_a != 10'd100) bad++;
    end
    chk("single_quiet", bad, 0);
    chk("single_rsp_seen", rsp_valid, 1);
    chk("single_id", rsp_id, 0);
    chk("single_q", rsp_q, 14);
    chk("single_dvz", rsp_dvz, 0);
    chk("single_err", rsp_err, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("single_ack", rsp_valid, 0);

    // Divide by zero from id2 (pointer at 0, so 1 then 2 are scanned).
    req = 4'b0100; #1;
    chk("dvz_gnt", gnt, 4'b0100);
    @(negedge clk); req = '0;
    wait_rsp("dvz", 40);
    chk("dvz_id", rsp_id, 2);
    chk("dvz_flag", rsp_dvz, 1);
    chk("dvz_err", rsp_err, 0);
    @(negedge clk);

    // Backpressure with all requests up: id3 is next after 2.
    rsp_ready = 1'b0; req = 4'b1111; #1;
    chk("bp_gnt", gnt, 4'b1000);
    @(negedge clk);
    wait_rsp("bp", 40);
    chk("bp_id", rsp_id, 3);
    chk("bp_q", rsp_q, 333);
    s_q = rsp_q; s_id = rsp_id; s_dvz = rsp_dvz;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (gnt != 0 || div_start || !rsp_valid || rsp_q !== s_q || rsp_id !== s_id ||
          rsp_dvz !== s_dvz || rsp_err) bad++;
    end
    chk("bp_hold", bad, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_next", gnt, 4'b0001);

    // Fairness with all requests held: 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (gnt == 0 && n < 60) begin
        @(negedge clk); n++;
      end
      id = oh2id(gnt);
      chk($sformatf("fair_id%0d", k), id, exp_ids[k]);
      @(negedge clk);
      if (k == 4) req = '0;
      wait_rsp($sformatf("fair%0d", k), 40);
      chk($sformatf("fair_rsp_id%0d", k), rsp_id, exp_ids[k]);
      chk($sformatf("fair_q%0d", k), rsp_q, exp_q[exp_ids[k]]);
      @(negedge clk);
    end

    // div_valid in the last counted cycle beats the timeout (TIMEOUT 64).
    m_lat = 63; req = 4'b0010; #1;
    chk("tie_gnt", gnt, 4'b0010);
    @(negedge clk); req = '0;
    wait_rsp("tie", 100);
    chk("tie_err", rsp_err, 0);
    chk("tie_q", rsp_q, 33);
    chk("tie_sclr", div_sclr, 0);
    @(negedge clk);

    // One cycle later the timeout wins.
    m_lat = 64; req = 4'b0100; #1;
    chk("late_gnt", gnt, 4'b0100);
    @(negedge clk); req = '0;
    wait_rsp("late", 100);
    chk("late_err", rsp_err, 1);
    chk("late_q", rsp_q, 0);
    chk("late_id", rsp_id, 2);
    chk("late_sclr", div_sclr, 1);
    @(negedge clk);

    // Reset in the middle of WAIT.
    m_lat = 12; req = 4'b0010; #1;
    chk("rw_gnt", gnt, 4'b0010);
    @(negedge clk); req = '0;
    chk("rw_start", div_start, 1);
    repeat (3) @(negedge clk);
    chk("rw_in_wait_a", div_a, 300);
    rst_n = 1'b0; #1;
    chk("rw_rst_valid", rsp_valid, 0);
    chk("rw_rst_a", div_a, 0);
    chk("rw_rst_b", div_b, 0);
    chk("rw_rst_sclr", div_sclr, 0);
    req = 4'b1111;
    bad = 0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid || gnt != 0 || div_start || div_sclr) bad++;
    end
    chk("rw_hold", bad, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rw_sclr", div_sclr, 1);
    chk("rw_next", gnt, 4'b0001);
    @(negedge clk); req = '0;
    chk("rw_sclr_pulse", div_sclr, 0);
    wait_rsp("rw", 40);
    chk("rw_id", rsp_id, 0);
    chk("rw_q", rsp_q, 14);
    chk("rw_err", rsp_err, 0);
    @(negedge clk);

    // Timeout on the instance whose divider never answers (TIMEOUT 8).
    rst_n = 1'b0; req = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    req = 4'b0001; #1;
    chk("to_gnt", t_gnt, 4'b0001);
    @(negedge clk); req = '0;
    chk("to_start", t_div_start, 1);
    n = 0;
    while (!t_div_sclr && n < 40) begin
      @(negedge clk); n++;
    end
    chk("to_cycles", n, 9);
    chk("to_valid", t_rsp_valid, 1);
    chk("to_err", t_rsp_err, 1);
    chk("to_q", t_rsp_q, 0);
    chk("to_id", t_rsp_id, 0);
    @(negedge clk);
    chk("to_sclr_pulse", t_div_sclr, 0);
    chk("to_hold_valid", t_rsp_valid, 1);
    chk("to_hold_err", t_rsp_err, 1);
    rsp_ready = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
